// File: rtl/irq_ctrl.sv
// Platform interrupt controller: latches 8 sources, arbitrates by programmable
// priority, and exposes claim/complete through a small register window.
module irq_ctrl #(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_b_i,
  input  logic        bus_rstb_i,
  input  logic [7:0]  bus_addr_i,
  input  logic [31:0] bus_data_i,
  input  logic [3:0]  bus_mask_i,
  output logic [31:0] bus_data_o,
  input  logic [7:0]  irq_src_i,
  input  logic [31:0] csr_mie_i,
  output logic        irq_master_o,
  output logic [7:0]  irq_bus_o
);

  typedef enum logic {ST_IDLE, ST_SERVICE} state_t;

  state_t                    r_state;
  logic [N_SRC-1:0]          r_src_q;
  logic [N_SRC-1:0]          r_pending;
  logic [N_SRC-1:0]          r_enable;
  logic [N_SRC-1:0]          r_trigger;
  logic [N_SRC*PRIO_W-1:0]   r_prio;
  logic [PRIO_W-1:0]         r_thresh;
  logic                      r_win_valid;
  logic [2:0]                r_win_id;
  logic [2:0]                r_svc_id;
  logic [31:0]               r_rdata;
  logic [N_SRC-1:0]          r_irq_bus;

  logic [2:0]                w_sel;
  logic                      w_wr;
  logic                      w_wr_pend;
  logic                      w_wr_cmp;
  logic                      w_claim;
  logic [N_SRC-1:0]          w_elig;
  logic                      w_best_v;
  logic [2:0]                w_best_id;
  logic [PRIO_W-1:0]         w_best_p;
  logic [N_SRC-1:0]          w_pend_nxt;
  logic [31:0]               w_rdata;
  logic                      w_unused;

  assign w_sel     = bus_addr_i[4:2];
  assign w_wr      = |bus_mask_i;
  assign w_wr_pend = w_wr && (w_sel == 3'd0) && bus_mask_i[0];
  assign w_wr_cmp  = w_wr && (w_sel == 3'd5) && bus_mask_i[0];
  assign w_claim   = bus_rstb_i && (w_sel == 3'd5) && (r_state == ST_IDLE) && r_win_valid;
  assign w_unused  = ^{bus_addr_i[7:5], bus_addr_i[1:0], csr_mie_i[31:24],
                       csr_mie_i[15:0], bus_data_i[31:16]};

  // Strict '>' keeps the lowest index on priority ties.
  always_comb begin
    w_elig    = '0;
    w_best_v  = 1'b0;
    w_best_id = '0;
    w_best_p  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      w_elig[i] = r_pending[i] && r_enable[i] && csr_mie_i[16+i] &&
                  (r_prio[PRIO_W*i +: PRIO_W] > r_thresh);
      if (w_elig[i] && (!w_best_v || (r_prio[PRIO_W*i +: PRIO_W] > w_best_p))) begin
        w_best_v  = 1'b1;
        w_best_id = 3'(i);
        w_best_p  = r_prio[PRIO_W*i +: PRIO_W];
      end
    end
  end

  // A new edge outranks both W1C and the claim-clear in the same cycle.
  always_comb begin
    w_pend_nxt = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (r_trigger[i]) begin
        w_pend_nxt[i] = (irq_src_i[i] && !r_src_q[i]) ||
                        (r_pending[i] && !((w_wr_pend && bus_data_i[i]) ||
                                           (w_claim && (r_win_id == 3'(i)))));
      end else begin
        w_pend_nxt[i] = irq_src_i[i];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      3'd0: w_rdata = {24'b0, r_pending};
      3'd1: w_rdata = {24'b0, r_enable};
      3'd2: w_rdata = {24'b0, r_trigger};
      3'd3: w_rdata = {16'b0, r_prio};
      3'd4: w_rdata = {30'b0, r_thresh};
      3'd5: w_rdata = w_claim ? (32'(r_win_id) + 32'd1) : '0;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      r_state     <= ST_IDLE;
      r_src_q     <= '0;
      r_pending   <= '0;
      r_enable    <= '0;
      r_trigger   <= '0;
      r_prio      <= '0;
      r_thresh    <= '0;
      r_win_valid <= 1'b0;
      r_win_id    <= '0;
      r_svc_id    <= '0;
      r_rdata     <= '0;
      r_irq_bus   <= '0;
    end else begin
      r_src_q     <= irq_src_i;
      r_pending   <= w_pend_nxt;
      r_win_valid <= w_best_v;
      r_win_id    <= w_best_id;
      r_irq_bus   <= r_pending & r_enable;
      if (bus_rstb_i) r_rdata <= w_rdata;

      if (w_wr && (w_sel == 3'd1) && bus_mask_i[0]) r_enable  <= bus_data_i[7:0];
      if (w_wr && (w_sel == 3'd2) && bus_mask_i[0]) r_trigger <= bus_data_i[7:0];
      if (w_wr && (w_sel == 3'd3) && bus_mask_i[0]) r_prio[7:0]  <= bus_data_i[7:0];
      if (w_wr && (w_sel == 3'd3) && bus_mask_i[1]) r_prio[15:8] <= bus_data_i[15:8];
      if (w_wr && (w_sel == 3'd4) && bus_mask_i[0]) r_thresh <= bus_data_i[1:0];

      case (r_state)
        ST_IDLE: begin
          if (w_claim) begin
            r_svc_id <= r_win_id;
            r_state  <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (w_wr_cmp && (bus_data_i[2:0] == r_svc_id)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_data_o   = r_rdata;
  assign irq_bus_o    = r_irq_bus;
  assign irq_master_o = r_win_valid && (r_state == ST_IDLE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized bench for irq_ctrl against a cycle-level
// behavioural model of the interrupt controller.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        rstb = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask = '0;
  logic [31:0] rdata;
  logic [7:0]  src = '0;
  logic [31:0] mie = '0;
  logic        master;
  logic [7:0]  ibus;

  int n_cmp = 0;
  int n_bad = 0;

  irq_ctrl #(.N_SRC(8), .PRIO_W(2)) dut (
    .clk_i(clk), .rst_b_i(rst_b), .bus_rstb_i(rstb), .bus_addr_i(addr),
    .bus_data_i(wdata), .bus_mask_i(mask), .bus_data_o(rdata),
    .irq_src_i(src), .csr_mie_i(mie), .irq_master_o(master), .irq_bus_o(ibus)
  );

  always #5 clk = ~clk;

  // Model state
  logic [7:0]  m_srcq, m_pend, m_en, m_trig, m_ibus;
  int          m_p[8];
  int          m_thr, m_wid, m_svc;
  bit          m_wv, m_busy;
  logic [31:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int sel, nid, bp;
    bit wr, claim, nv, set, clr;
    logic [31:0] rv;
    logic [7:0]  np, nb;
    if (!rst_b) begin
      m_srcq = '0; m_pend = '0; m_en = '0; m_trig = '0; m_ibus = '0;
      for (int i = 0; i < 8; i++) m_p[i] = 0;
      m_thr = 0; m_wid = 0; m_svc = 0; m_wv = 0; m_busy = 0; m_rdata = '0;
      return;
    end
    sel = int'(addr[4:2]);
    wr  = (mask != 4'd0);
    rv  = '0;
    case (sel)
      0: rv = {24'b0, m_pend};
      1: rv = {24'b0, m_en};
      2: rv = {24'b0, m_trig};
      3: for (int i = 0; i < 8; i++) rv = rv | (32'(m_p[i]) << (2 * i));
      4: rv = 32'(m_thr);
      5: rv = (m_busy || !m_wv) ? 32'd0 : 32'(m_wid + 1);
      default: rv = '0;
    endcase
    claim = rstb && (sel == 5) && !m_busy && m_wv;
    nv = 0; nid = 0; bp = -1;
    for (int i = 0; i < 8; i++)
      if (m_pend[i] && m_en[i] && mie[16+i] && (m_p[i] > m_thr) && (m_p[i] > bp)) begin
        nv = 1; nid = i; bp = m_p[i];
      end
    for (int i = 0; i < 8; i++) begin
      if (m_trig[i]) begin
        set = src[i] && !m_srcq[i];
        clr = (wr && sel == 0 && mask[0] && wdata[i]) || (claim && m_wid == i);
        np[i] = set || (m_pend[i] && !clr);
      end else begin
        np[i] = src[i];
      end
    end
    nb = m_pend & m_en;
    if (wr && sel == 1 && mask[0]) m_en   = wdata[7:0];
    if (wr && sel == 2 && mask[0]) m_trig = wdata[7:0];
    if (wr && sel == 3)
      for (int i = 0; i < 8; i++)
        if (mask[i/4]) m_p[i] = int'((wdata >> (2 * i)) & 32'd3);
    if (wr && sel == 4 && mask[0]) m_thr = int'(wdata[1:0]);
    if (claim) begin
      m_busy = 1; m_svc = m_wid;
    end else if (m_busy && wr && sel == 5 && mask[0] && int'(wdata[2:0]) == m_svc) begin
      m_busy = 0;
    end
    m_pend = np; m_wv = nv; m_wid = nid; m_srcq = src; m_ibus = nb;
    if (rstb) m_rdata = rv;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("irq_master", 32'(master), 32'(m_wv && !m_busy));
    chk("irq_bus", 32'(ibus), 32'(m_ibus));
    chk("bus_data", rdata, m_rdata);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; mask = m;
    tick();
    mask = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    addr = a; rstb = 1'b1;
    tick();
    rstb = 1'b0;
    d = rdata;
  endtask

  task automatic pulse(input logic [7:0] s);
    src = s; tick();
    src = '0; tick();
  endtask

  logic [31:0] d;
  int sel_r;

  initial begin
    // Reset state
    rst_b = 1'b0; tick(); tick();
    rst_b = 1'b1;
    chk("reset_master", 32'(master), 32'd0);
    chk("reset_data", rdata, 32'd0);
    chk("reset_ibus", 32'(ibus), 32'd0);

    // Edge, basic flow
    mie = 32'h0001_0000;
    wr(8'h08, 32'h01, 4'h1); wr(8'h04, 32'h01, 4'h1);
    wr(8'h0C, 32'h0001, 4'h3); wr(8'h10, 32'h0, 4'h1);
    pulse(8'h01);
    chk("edge_master_2cyc", 32'(master), 32'd1);
    rd(8'h14, d); chk("edge_claim", d, 32'd1);
    chk("edge_master_svc", 32'(master), 32'd0);
    rd(8'h00, d); chk("edge_pending_clr", d, 32'd0);
    wr(8'h14, 32'd0, 4'h1); tick();
    chk("edge_idle_master", 32'(master), 32'd0);

    // Priority and tie-break
    mie = 32'h00FF_0000;
    wr(8'h08, 32'h26, 4'h1); wr(8'h04, 32'h26, 4'h1);
    wr(8'h0C, 32'h0C38, 4'h3);
    pulse(8'h26); tick();
    rd(8'h14, d); chk("prio_claim_a", d, 32'd3);
    wr(8'h14, 32'd2, 4'h1); tick();
    rd(8'h14, d); chk("prio_claim_b", d, 32'd6);
    wr(8'h14, 32'd5, 4'h1); tick();
    rd(8'h14, d); chk("prio_claim_c", d, 32'd2);
    wr(8'h14, 32'd1, 4'h1); tick();

    // Threshold and mask
    wr(8'h08, 32'h2E, 4'h1); wr(8'h04, 32'h08, 4'h1);
    wr(8'h0C, 32'h0040, 4'h3); wr(8'h10, 32'h1, 4'h1);
    pulse(8'h08); tick();
    chk("thr_no_master", 32'(master), 32'd0);
    chk("thr_ibus3", 32'(ibus[3]), 32'd1);
    mie = 32'h00F7_0000;
    wr(8'h10, 32'h0, 4'h1); tick(); tick();
    chk("mie_no_master", 32'(master), 32'd0);
    mie = 32'h00FF_0000;
    tick(); tick();
    chk("mie_master", 32'(master), 32'd1);
    rd(8'h14, d); chk("thr_claim", d, 32'd4);
    wr(8'h14, 32'd3, 4'h1);

    // Level source
    wr(8'h04, 32'h10, 4'h1); wr(8'h0C, 32'h0100, 4'h3);
    src = 8'h10; tick(); tick();
    rd(8'h14, d); chk("lvl_claim", d, 32'd5);
    wr(8'h14, 32'd4, 4'h1); tick();
    chk("lvl_remaster", 32'(master), 32'd1);
    src = 8'h00; tick();
    rd(8'h00, d); chk("lvl_pend_drop", d, 32'd0);

    // Wrong complete and empty claim
    wr(8'h04, 32'h04, 4'h1); wr(8'h0C, 32'h0030, 4'h3);
    pulse(8'h04);
    rd(8'h14, d); chk("wc_claim", d, 32'd3);
    wr(8'h14, 32'd3, 4'h1);
    rd(8'h14, d); chk("wc_still_svc", d, 32'd0);
    chk("wc_master", 32'(master), 32'd0);
    wr(8'h14, 32'd2, 4'h1); tick();
    rd(8'h14, d); chk("empty_claim", d, 32'd0);

    // Reset in service
    pulse(8'h04);
    rd(8'h14, d); chk("rs_claim", d, 32'd3);
    rst_b = 1'b0; tick(); rst_b = 1'b1;
    chk("rs_master", 32'(master), 32'd0);
    chk("rs_data", rdata, 32'd0);
    rd(8'h04, d); chk("rs_enable", d, 32'd0);

    // Randomized traffic checked cycle-by-cycle by the model
    for (int n = 0; n < 3000; n++) begin
      rst_b = ($urandom_range(0, 199) != 0);
      src   = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      mie   = ($urandom_range(0, 4) != 0) ? 32'h00FF_0000 : $urandom;
      sel_r = $urandom_range(0, 9);
      addr  = (sel_r < 4) ? 8'h14 : 8'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      rstb  = ($urandom_range(0, 2) == 0);
      mask  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      wdata = $urandom;
      if (addr[4:2] == 3'd0) wdata[7:0] = 8'($urandom) & 8'($urandom);
      tick();
    end
    rstb = 1'b0; mask = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
